// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: serialises CPU (A) and
// peripheral (B) accesses, round-robin on ties, read data returned with a valid pulse.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Port id encoding: 0 = A, 1 = B.
    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mem_en_q, mem_we_q;
    logic                pick_b;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pick_b  = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // B wins when alone, or on a tie when A was served last.
                    pick_b  = b_req && (!a_req || !last_q);
                    sel_d   = pick_b;
                    last_d  = pick_b;
                    we_d    = pick_b ? b_we    : a_we;
                    addr_d  = pick_b ? b_addr  : a_addr;
                    wdata_d = pick_b ? b_wdata : a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_en_q <= (state_d == ACCESS);
            mem_we_q <= (state_d == ACCESS) && we_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    logic [1:0]        gnt_w;
    logic [1:0]        rvalid_w;
    logic [DATA_W-1:0] rdata_w [2];

    // Per-port response registers; only the selected port's rdata is ever updated.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT_ID = 1'(gi);
        logic              gnt_q;
        logic              rvalid_q;
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                gnt_q    <= 1'b0;
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                gnt_q    <= (state_d == ACCESS) && (sel_d == PORT_ID);
                rvalid_q <= (state_q == RESP) && (sel_q == PORT_ID);
                if ((state_q == RESP) && (sel_q == PORT_ID)) begin
                    rdata_q <= mem_rdata;
                end
            end
        end

        assign gnt_w[gi]    = gnt_q;
        assign rvalid_w[gi] = rvalid_q;
        assign rdata_w[gi]  = rdata_q;
    end

    assign a_gnt    = gnt_w[0];
    assign b_gnt    = gnt_w[1];
    assign a_rvalid = rvalid_w[0];
    assign b_rvalid = rvalid_w[1];
    assign a_rdata  = rdata_w[0];
    assign b_rdata  = rdata_w[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM (one-cycle read).
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] ram [0:65535];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int order [4];
    int ng, both, na, got;

    initial begin
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hBEEF;
        tick();
        pre_we = 1'b0;
        tick();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;

        // A read alone
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        tick();
        check("t1_a_gnt", a_gnt, 1);
        check("t1_b_gnt", b_gnt, 0);
        check("t1_mem_en", mem_en, 1);
        check("t1_mem_we", mem_we, 0);
        check("t1_mem_addr", mem_addr, 16'h0010);
        a_req = 0;
        tick();
        check("t1_gnt_pulse", a_gnt, 0);
        check("t1_rvalid_early", a_rvalid, 0);
        check("t1_mem_en_resp", mem_en, 0);
        tick();
        check("t1_a_rvalid", a_rvalid, 1);
        check("t1_a_rdata", a_rdata, 16'hBEEF);
        check("t1_b_rvalid", b_rvalid, 0);
        check("t1_b_rdata", b_rdata, 0);
        tick();
        check("t1_rvalid_pulse", a_rvalid, 0);

        // B write then A read of same address
        b_req = 1; b_we = 1; b_addr = 16'h0020; b_wdata = 16'h1234;
        tick();
        check("t2_b_gnt", b_gnt, 1);
        check("t2_a_gnt", a_gnt, 0);
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_addr", mem_addr, 16'h0020);
        check("t2_mem_wdata", mem_wdata, 16'h1234);
        b_req = 0;
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        tick();
        check("t2_idle_mem_we", mem_we, 0);
        check("t2_idle_mem_en", mem_en, 0);
        check("t2_idle_a_gnt", a_gnt, 0);
        tick();
        check("t2_a_gnt", a_gnt, 1);
        check("t2_rd_mem_we", mem_we, 0);
        check("t2_rd_mem_addr", mem_addr, 16'h0020);
        a_req = 0;
        tick();
        tick();
        check("t2_a_rvalid", a_rvalid, 1);
        check("t2_a_rdata", a_rdata, 16'h1234);
        check("t2_b_rdata", b_rdata, 0);

        // Simultaneous requests after reset: A, B, A, B
        reset = 1;
        tick();
        reset = 0;
        check("t3_rst_a_rdata", a_rdata, 0);
        a_req = 1; a_we = 1; a_addr = 16'h0030; a_wdata = 16'hAAAA;
        b_req = 1; b_we = 1; b_addr = 16'h0040; b_wdata = 16'h5555;
        ng = 0; both = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            tick();
            if (a_gnt && b_gnt) both++;
            if (a_gnt && ng < 4) begin order[ng] = 0; ng++; end
            if (b_gnt && ng < 4) begin order[ng] = 1; ng++; end
        end
        a_req = 0; b_req = 0;
        check("t3_grant_count", ng, 4);
        check("t3_both_gnt", both, 0);
        check("t3_order0", order[0], 0);
        check("t3_order1", order[1], 1);
        check("t3_order2", order[2], 0);
        check("t3_order3", order[3], 1);
        tick();
        check("t3_ram_a", ram[16'h0030], 16'hAAAA);
        check("t3_ram_b", ram[16'h0040], 16'h5555);

        // A streaming reads, B writes once
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        b_we = 1; b_addr = 16'h0050; b_wdata = 16'h5A5A;
        tick();
        check("t4_a_first", a_gnt, 1);
        b_req = 1;
        na = 0; got = 0;
        for (int c = 0; c < 12 && got == 0; c++) begin
            tick();
            if (b_gnt) got = 1;
            else if (a_gnt) na++;
        end
        check("t4_b_granted", got, 1);
        check("t4_a_before_b", na, 0);
        check("t4_mem_addr", mem_addr, 16'h0050);
        check("t4_mem_wdata", mem_wdata, 16'h5A5A);
        check("t4_mem_we", mem_we, 1);
        b_req = 0;
        tick();
        tick();
        check("t4_a_resume", a_gnt, 1);
        a_req = 0;
        tick();
        tick();
        check("t4_a_rvalid", a_rvalid, 1);
        check("t4_a_rdata", a_rdata, 16'hBEEF);
        check("t4_ram_b", ram[16'h0050], 16'h5A5A);
        check("t4_b_rdata", b_rdata, 0);

        // Reset during RESP of an A read
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        tick();
        check("t5_a_gnt", a_gnt, 1);
        a_req = 0;
        tick();
        check("t5_resp_rvalid", a_rvalid, 0);
        reset = 1;
        tick();
        reset = 0;
        check("t5_rst_rvalid", a_rvalid, 0);
        check("t5_rst_rdata", a_rdata, 0);
        check("t5_rst_mem_en", mem_en, 0);
        tick();
        check("t5_no_rvalid", a_rvalid, 0);
        check("t5_rdata_zero", a_rdata, 0);
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        b_req = 1; b_we = 0; b_addr = 16'h0010;
        tick();
        check("t5_tie_a_gnt", a_gnt, 1);
        check("t5_tie_b_gnt", b_gnt, 0);
        a_req = 0;
        tick();
        tick();
        check("t5_a_rvalid", a_rvalid, 1);
        check("t5_a_rdata", a_rdata, 16'h1234);
        tick();
        check("t5_b_gnt", b_gnt, 1);
        b_req = 0;
        tick();
        tick();
        check("t5_b_rvalid", b_rvalid, 1);
        check("t5_b_rdata", b_rdata, 16'hBEEF);
        check("t5_a_rdata_held", a_rdata, 16'h1234);

        // Boundary write at 0xFFFF
        a_req = 1; a_we = 1; a_addr = 16'hFFFF; a_wdata = 16'hFFFF;
        check("t6_pre_mem_we", mem_we, 0);
        tick();
        check("t6_a_gnt", a_gnt, 1);
        check("t6_mem_we", mem_we, 1);
        check("t6_mem_addr", mem_addr, 16'hFFFF);
        check("t6_mem_wdata", mem_wdata, 16'hFFFF);
        a_req = 0;
        tick();
        check("t6_post_mem_we", mem_we, 0);
        check("t6_post_mem_en", mem_en, 0);
        check("t6_addr_held", mem_addr, 16'hFFFF);
        b_req = 1; b_we = 0; b_addr = 16'hFFFF;
        tick();
        check("t6_b_gnt", b_gnt, 1);
        b_req = 0;
        tick();
        tick();
        check("t6_b_rvalid", b_rvalid, 1);
        check("t6_b_rdata", b_rdata, 16'hFFFF);
        check("t6_a_rdata_held", a_rdata, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
